// File: rtl/scan_mux_pkg.sv
// Shared mode encodings and select-width helper for the scan_mux channel selector.
package scan_mux_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_STEP   = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // A select bus is never narrower than one bit, even for two channels.
    function automatic int calc_selw(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
module tick_divider #(
    parameter int DIV = 50000000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_base;

    // A clear in the same cycle as enable counts that cycle as count 0.
    assign w_cnt_base = clr ? '0 : r_cnt;
    assign tick       = en && (w_cnt_base == LAST);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : w_cnt_base + ONE;
        end else if (clr) begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel selector with manual, timed auto-scan, key-step and hold modes.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int  NCH      = 4,
    parameter int  W        = 4,
    parameter int  TICK_DIV = 50000000,
    localparam int SELW     = calc_selw(NCH)
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [NCH*W-1:0]  din,
    input  logic [1:0]        mode,
    input  logic [SELW-1:0]   sel,
    input  logic              step_n,
    output logic [W-1:0]      dout,
    output logic [SELW-1:0]   cur_ch,
    output logic              ch_chg,
    output logic              sel_err
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
    localparam logic [SELW-1:0] ONE_CH  = SELW'(1);
    localparam logic [SELW:0]   NCH_EXT = (SELW + 1)'(NCH);

    logic            r_sync1, r_sync2, r_sync_d;
    logic            r_prev_auto;
    logic [SELW-1:0] r_cur_ch;
    logic [W-1:0]    r_dout;
    logic            r_ch_chg, r_sel_err;

    logic            w_press, w_auto, w_auto_entry, w_tick, w_err;
    logic [SELW-1:0] w_next_ch, w_inc_ch;
    logic [W-1:0]    w_dsel;

    // Key is asynchronous; a press is a 1->0 transition after the two-flop synchroniser.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= step_n;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_press      = r_sync_d & ~r_sync2;
    assign w_auto       = (mode == MODE_AUTO);
    assign w_auto_entry = w_auto & ~r_prev_auto;

    tick_divider #(
        .DIV (TICK_DIV)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .clr      (w_auto_entry),
        .en       (w_auto),
        .tick     (w_tick)
    );

    assign w_inc_ch = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + ONE_CH;

    always_comb begin
        w_next_ch = r_cur_ch;
        w_err     = 1'b0;
        case (mode)
            MODE_MANUAL: begin
                if ({1'b0, sel} < NCH_EXT) w_next_ch = sel;
                else                       w_err     = 1'b1;
            end
            MODE_AUTO:   if (w_tick)  w_next_ch = w_inc_ch;
            MODE_STEP:   if (w_press) w_next_ch = w_inc_ch;
            default:     w_next_ch = r_cur_ch;
        endcase
    end

    always_comb begin
        w_dsel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_next_ch == SELW'(k)) w_dsel = din[k*W +: W];
        end
    end

    // HOLD freezes the data register as well as the channel.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_cur_ch    <= '0;
            r_dout      <= '0;
            r_ch_chg    <= 1'b0;
            r_sel_err   <= 1'b0;
            r_prev_auto <= 1'b0;
        end else begin
            r_cur_ch    <= w_next_ch;
            r_ch_chg    <= (w_next_ch != r_cur_ch);
            r_sel_err   <= w_err;
            r_prev_auto <= w_auto;
            if (mode != MODE_HOLD) r_dout <= w_dsel;
        end
    end

    assign dout    = r_dout;
    assign cur_ch  = r_cur_ch;
    assign ch_chg  = r_ch_chg;
    assign sel_err = r_sel_err;

endmodule
